lzc_normalizer: RTL and testbench

Pipelined leading-zero count and normalize unit for the COUNT_LEADING_ZEROES group. It is the consumer end of the boundary-nibble encoding. It derives per-nibble zero flags and the coarse boundary-nibble index from an input word. It then decodes that index into a one-hot nibble select and a coarse shift, applies the fine shift within the boundary nibble, and emits the normalized word together with the leading-zero count. Data enters and leaves through valid/ready handshakes; the unit sits between an operand source and FP/fixed-point normalization logic.

---
 rtl/lzc_pkg.sv | 18 +
 rtl/nibble_lzc.sv | 11 +
 rtl/lzc_normalizer.sv | 93 +++++++++
 tb/tb_lzc_normalizer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// lzc_pkg: shared nibble width, count-width function, zero-nibble test and registered S1 payload for lzc_normalizer
package lzc_pkg;
  localparam int NIB_W = 4;
  localparam int MAX_NIB = 16;
  localparam int MAX_W = NIB_W * MAX_NIB;
  typedef struct packed {
    logic [MAX_W-1:0]   data;
    logic [MAX_NIB-1:0] z;
    logic [3:0]         c;
    logic               zero;
  } s1_t;
  function automatic int count_width(input int w);
    return $clog2(w) + 1;
  endfunction
  function automatic logic nib_zero(input logic [NIB_W-1:0] n);
    return n == '0;
  endfunction
endpackage

// File: rtl/nibble_lzc.sv
// nibble_lzc: combinational 4-bit leading-zero count; in nib, out f (0..3) and zero (nib==0)
module nibble_lzc
  import lzc_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [1:0]       f,
  output logic             zero
);
  assign f = nib[3] ? 2'd0 : nib[2] ? 2'd1 : nib[1] ? 2'd2 : 2'd3;
  assign zero = nib_zero(nib);
endmodule

// File: rtl/lzc_normalizer.sv
// lzc_normalizer: 2-stage LZC/normalize, ports i_CLK i_RST_N, in i_VALID/o_READY/i_DATA, out o_VALID/i_READY/o_NORM/o_COUNT/o_ZERO; LZC_NORMALIZER_FORMAL_EN adds assertions
module lzc_normalizer
  import lzc_pkg::*;
#(
  parameter  int NIBBLES = 8,
  localparam int W       = NIB_W * NIBBLES,
  localparam int CW      = count_width(W)
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  input  logic          i_VALID,
  output logic          o_READY,
  input  logic [W-1:0]  i_DATA,
  output logic          o_VALID,
  input  logic          i_READY,
  output logic [W-1:0]  o_NORM,
  output logic [CW-1:0] o_COUNT,
  output logic          o_ZERO
);
  s1_t s1_d, s1_q;
  logic s1_valid;
  logic adv1, adv2;
  logic [W-1:0] d, coarse, norm_d;
  logic [NIBBLES-1:0] sel;
  logic [NIB_W-1:0] bnd;
  logic [1:0] f;
  logic bnd_zero;
  logic [CW-1:0] count_d;
  assign adv2 = ~o_VALID | i_READY;
  assign adv1 = ~s1_valid | adv2;
  assign o_READY = adv1;
  always_comb begin
    s1_d = '0;
    s1_d.data[W-1:0] = i_DATA;
    s1_d.c = 4'(NIBBLES - 1);
    for (int k = NIBBLES - 1; k >= 0; k--) begin
      s1_d.z[k] = nib_zero(i_DATA[W-1-NIB_W*k -: NIB_W]);
      if (!s1_d.z[k]) s1_d.c = 4'(k);
    end
    s1_d.zero = &s1_d.z[NIBBLES-1:0];
  end
  assign d = s1_q.data[W-1:0];
  assign sel = NIBBLES'(1) << s1_q.c;
  always_comb begin
    bnd = '0;
    for (int k = 0; k < NIBBLES; k++)
      bnd = bnd | (sel[k] ? d[W-1-NIB_W*k -: NIB_W] : '0);
  end
  nibble_lzc u_fine (
    .nib  (bnd),
    .f    (f),
    .zero (bnd_zero)
  );
  assign coarse = d << {s1_q.c, 2'b00};
  // An all-zero word lands on the last nibble with f=3, so count/norm are overridden.
  assign norm_d = s1_q.zero ? '0 : coarse << f;
  assign count_d = s1_q.zero ? CW'(W) : CW'({s1_q.c, 2'b00}) + CW'(f);
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      o_VALID  <= 1'b0;
      o_NORM   <= '0;
      o_COUNT  <= '0;
      o_ZERO   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= i_VALID;
        s1_q     <= s1_d;
      end
      if (adv2) begin
        o_VALID <= s1_valid;
        if (s1_valid) begin
          o_NORM  <= norm_d;
          o_COUNT <= count_d;
          o_ZERO  <= s1_q.zero | bnd_zero;
        end
      end
    end
  end
`ifdef LZC_NORMALIZER_FORMAL_EN
  a_norm_msb: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    o_VALID && !o_ZERO |-> o_NORM[W-1]);
  a_zero_count: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    o_VALID |-> ((o_COUNT == CW'(W)) == o_ZERO));
  a_stall_stable: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    o_VALID && !i_READY |=> o_VALID && $stable(o_NORM) && $stable(o_COUNT) && $stable(o_ZERO));
  a_post_reset: assert property (@(posedge i_CLK)
    i_RST_N && !$past(i_RST_N) |-> !o_VALID);
  c_last_nibble: cover property (@(posedge i_CLK) disable iff (!i_RST_N)
    s1_valid && s1_q.c == 4'(NIBBLES - 1));
`endif
endmodule

// File: tb/tb_lzc_normalizer.sv
// tb_lzc_normalizer: table, directed and random checks of lzc_normalizer against a bit-scan model
module tb_lzc_normalizer;
  typedef struct {
    logic [31:0] data;
    logic [5:0]  count;
    logic [31:0] norm;
    logic        zero;
  } vec_t;
  logic        i_CLK = 1'b0;
  logic        i_RST_N = 1'b0;
  logic        i_VALID = 1'b0;
  logic        o_READY;
  logic [31:0] i_DATA = '0;
  logic        o_VALID;
  logic        i_READY = 1'b0;
  logic [31:0] o_NORM;
  logic [5:0]  o_COUNT;
  logic        o_ZERO;
  int checks = 0;
  int errors = 0;
  int outs = 0;
  bit throttle = 1'b0;
  bit rdy_force = 1'b1;
  vec_t pend_q[$];
  vec_t exp_q[$];
  vec_t tbl[8];
  lzc_normalizer #(.NIBBLES(8)) dut (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .i_VALID (i_VALID),
    .o_READY (o_READY),
    .i_DATA  (i_DATA),
    .o_VALID (o_VALID),
    .i_READY (i_READY),
    .o_NORM  (o_NORM),
    .o_COUNT (o_COUNT),
    .o_ZERO  (o_ZERO)
  );
  always #5 i_CLK = ~i_CLK;
  function automatic vec_t model(input logic [31:0] d);
    vec_t v;
    int n = 0;
    while (n < 32 && d[31-n] == 1'b0) n++;
    v.data = d;
    v.count = 6'(n);
    v.zero = (n == 32);
    v.norm = (n == 32) ? 32'h0 : d << n;
    return v;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  always @(posedge i_CLK) begin
    #1;
    i_VALID = pend_q.size() != 0;
    i_DATA = pend_q.size() != 0 ? pend_q[0].data : 32'h0;
    i_READY = throttle ? 1'($urandom_range(0, 1)) : rdy_force;
  end
  always @(negedge i_CLK) begin
    if (!i_RST_N) exp_q.delete();
    else begin
      if (o_VALID && i_READY) begin
        vec_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got count=%0d norm=%h, expected no output", o_COUNT, o_NORM);
        end else begin
          e = exp_q.pop_front();
          if (o_COUNT !== e.count || o_NORM !== e.norm || o_ZERO !== e.zero) begin
            errors++;
            $display("FAIL out[%0d] data=%h: got count=%0d norm=%h zero=%b, expected count=%0d norm=%h zero=%b",
                     outs, e.data, o_COUNT, o_NORM, o_ZERO, e.count, e.norm, e.zero);
          end
        end
        outs++;
      end
      if (i_VALID && o_READY && pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
    end
  end
  task automatic send(input logic [31:0] d);
    pend_q.push_back(model(d));
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && (pend_q.size() != 0 || exp_q.size() != 0); i++) @(negedge i_CLK);
    #1;
    chk({name, "_drain"}, 64'(pend_q.size() + exp_q.size()), 64'd0);
  endtask
  task automatic wait_two(input string name);
    int i;
    for (i = 0; i < 50 && exp_q.size() < 2; i++) begin
      @(negedge i_CLK);
      #1;
    end
    chk({name, "_fill"}, 64'(exp_q.size()), 64'd2);
  endtask
  initial begin
    tbl[0] = '{32'h80000000, 6'd0,  32'h80000000, 1'b0};
    tbl[1] = '{32'h00000001, 6'd31, 32'h80000000, 1'b0};
    tbl[2] = '{32'h00F00000, 6'd8,  32'hF0000000, 1'b0};
    tbl[3] = '{32'h00003A5C, 6'd18, 32'hE9700000, 1'b0};
    tbl[4] = '{32'h00000000, 6'd32, 32'h00000000, 1'b1};
    tbl[5] = '{32'hFFFFFFFF, 6'd0,  32'hFFFFFFFF, 1'b0};
    tbl[6] = '{32'h0000F000, 6'd16, 32'hF0000000, 1'b0};
    tbl[7] = '{32'h08000001, 6'd4,  32'h80000010, 1'b0};
    repeat (2) @(posedge i_CLK);
    #1;
    chk("rst_valid", 64'(o_VALID), 64'd0);
    chk("rst_outs", {o_NORM, 26'(o_COUNT), o_ZERO}, 64'd0);
    @(negedge i_CLK);
    #2 i_RST_N = 1'b1;
    @(negedge i_CLK);
    #1;
    chk("rel_ready", 64'(o_READY), 64'd1);
    chk("rel_valid", 64'(o_VALID), 64'd0);
    foreach (tbl[i]) pend_q.push_back(tbl[i]);
    wait_idle("table");
    rdy_force = 1'b0;
    send(32'h1);
    send(32'h2);
    send(32'h4);
    wait_two("stall");
    for (int i = 0; i < 3; i++) begin
      @(negedge i_CLK);
      #1;
      chk("stall_ready", 64'(o_READY), 64'd0);
      chk("stall_hold", {31'(o_VALID), o_NORM, 1'b0} | 64'(o_COUNT), {31'd1, 32'h80000000, 1'b0} | 64'd31);
    end
    rdy_force = 1'b1;
    @(posedge i_CLK);
    #2;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_CLK);
      #1;
      chk("release_seq", {32'(o_VALID), 32'(o_COUNT)}, {32'd1, 32'(31 - i)});
    end
    wait_idle("stall");
    rdy_force = 1'b0;
    send(32'h10);
    send(32'h20);
    send(32'h40);
    wait_two("rst");
    @(negedge i_CLK);
    #2 i_RST_N = 1'b0;
    pend_q.delete();
    #1;
    chk("midrst_valid", 64'(o_VALID), 64'd0);
    chk("midrst_outs", {o_NORM, 26'(o_COUNT), o_ZERO}, 64'd0);
    @(posedge i_CLK);
    @(negedge i_CLK);
    #2 i_RST_N = 1'b1;
    @(negedge i_CLK);
    #1;
    chk("post_rst_ready", 64'(o_READY), 64'd1);
    chk("post_rst_valid", 64'(o_VALID), 64'd0);
    rdy_force = 1'b1;
    send(32'h00F00000);
    begin
      int i;
      for (i = 0; i < 20 && !(i_VALID && o_READY); i++) begin
        @(negedge i_CLK);
        #1;
      end
      chk("lat_accept", 64'(i_VALID && o_READY), 64'd1);
    end
    @(negedge i_CLK);
    #1;
    chk("lat_cycle1", 64'(o_VALID), 64'd0);
    @(negedge i_CLK);
    #1;
    chk("lat_cycle2", {32'(o_VALID), 32'(o_COUNT)}, {32'd1, 32'd8});
    wait_idle("post_rst");
    throttle = 1'b1;
    for (int k = 0; k < 32; k++) send(32'h1 << k);
    send(32'h0);
    wait_idle("sweep");
    for (int i = 0; i < 300; i++) send(32'($urandom) >> $urandom_range(0, 32));
    wait_idle("random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule
